// File: rtl/key_entry_pkg.sv
// Shared types and default constants for the combination-lock key entry front end.
package key_entry_pkg;

   localparam int unsigned DIGIT_W             = 4;
   localparam int unsigned DEBOUNCE_CYCLES_DEF = 500000;
   localparam int unsigned CNT_W_DEF           = 20;
   localparam int unsigned CODE_DIGITS_DEF     = 4;
   localparam int unsigned TIMEOUT_CYCLES_DEF  = 250000000;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } deb_state_t;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchronizer plus press/release debouncer; emits one registered pulse per accepted press.
module key_debounce
   import key_entry_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       sync;
   logic             level;
   deb_state_t       state;
   logic [CNT_W-1:0] cnt;

   assign level = sync[1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync  <= '0;
         state <= IDLE;
         cnt   <= '0;
         press <= 1'b0;
      end else begin
         sync  <= {sync[0], btn};
         press <= 1'b0;
         case (state)
            IDLE: begin
               if (level) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!level) begin
                  state <= IDLE;
               end else if (cnt == CNT_LAST) begin
                  state <= PRESSED;
                  press <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!level) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end
            end
            RELEASE_WAIT: begin
               // a bounce on release returns to PRESSED without a new pulse
               if (level) begin
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/key_entry.sv
// Key entry stage: synchronizes switches, debounces ENTER/CLEAR, emits digit triggers and code framing.
// Optional inactivity timeout enabled by defining KEY_ENTRY_TIMEOUT_EN.
module key_entry
   import key_entry_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int unsigned CNT_W           = CNT_W_DEF,
   parameter int unsigned CODE_DIGITS     = CODE_DIGITS_DEF,
   parameter int unsigned TIMEOUT_CYCLES  = TIMEOUT_CYCLES_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [DIGIT_W-1:0] sw,
   input  logic               btn_enter,
   input  logic               btn_clear,
   output logic [DIGIT_W-1:0] digit,
   output logic               trigger,
   output logic               clear,
   output logic               code_done,
   output logic [1:0]         digit_count
);

   localparam logic [1:0] LAST_DIGIT = 2'(CODE_DIGITS - 1);

   if (DEBOUNCE_CYCLES < 2 || (64'd1 << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
       TIMEOUT_CYCLES < 2 || CODE_DIGITS < 1 || CODE_DIGITS > 4) begin : g_bad_param
      $error("key_entry: illegal parameter combination");
   end

   logic [DIGIT_W-1:0] sw_meta;
   logic [DIGIT_W-1:0] sw_sync;
   logic               press_enter;
   logic               press_clear;
   logic               timeout;
   logic               clear_evt;

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_enter (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_enter),
      .press   (press_enter)
   );

   key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_clear (
      .clk     (clk),
      .reset_n (reset_n),
      .btn     (btn_clear),
      .press   (press_clear)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_meta <= '0;
         sw_sync <= '0;
      end else begin
         sw_meta <= sw;
         sw_sync <= sw_meta;
      end
   end

`ifdef KEY_ENTRY_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);

   logic [TO_W-1:0] idle_cnt;

   assign timeout = (digit_count != 2'd0) && (idle_cnt == TO_W'(TIMEOUT_CYCLES - 1));

   // Inactivity counter: held at zero with no partial code, restarted by any accepted key.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idle_cnt <= '0;
      end else if (press_enter || clear_evt || digit_count == 2'd0) begin
         idle_cnt <= '0;
      end else begin
         idle_cnt <= idle_cnt + TO_W'(1);
      end
   end
`else
   assign timeout = 1'b0;
`endif

   // A clear request right after a clear pulse merges into it, keeping clear a single-cycle pulse.
   assign clear_evt = (press_clear || timeout) && !clear;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         digit       <= '0;
         trigger     <= 1'b0;
         clear       <= 1'b0;
         code_done   <= 1'b0;
         digit_count <= 2'd0;
      end else begin
         trigger   <= 1'b0;
         clear     <= 1'b0;
         code_done <= 1'b0;
         if (clear_evt) begin
            clear       <= 1'b1;
            digit_count <= 2'd0;
         end else if (press_enter) begin
            digit   <= sw_sync;
            trigger <= 1'b1;
            if (digit_count == LAST_DIGIT) begin
               code_done   <= 1'b1;
               digit_count <= 2'd0;
            end else begin
               digit_count <= digit_count + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_key_entry.sv
// Directed self-checking bench for key_entry with short debounce and timeout settings.
module tb_key_entry;

   localparam int unsigned DEB = 4;
   localparam int unsigned TO  = 50;
   // edge index (1 = first edge sampling the pin high) at which the registered pulse appears
   localparam int LAT = DEB + 4;

   logic       clk;
   logic       reset_n;
   logic [3:0] sw;
   logic       btn_enter;
   logic       btn_clear;
   logic [3:0] digit;
   logic       trigger;
   logic       clear;
   logic       code_done;
   logic [1:0] digit_count;

   int checks = 0;
   int errors = 0;
   int trig_cnt = 0;
   int clr_cnt = 0;
   int n;

   key_entry #(
      .DEBOUNCE_CYCLES(DEB),
      .CNT_W          (4),
      .CODE_DIGITS    (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .sw          (sw),
      .btn_enter   (btn_enter),
      .btn_clear   (btn_clear),
      .digit       (digit),
      .trigger     (trigger),
      .clear       (clear),
      .code_done   (code_done),
      .digit_count (digit_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (trigger) trig_cnt++;
      if (clear) clr_cnt++;
   endtask

   task automatic steps(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   // Returns the edge index of the first trigger or clear pulse, 0 if none within the bound.
   task automatic wait_evt(output int idx);
      bit done;
      idx  = 0;
      done = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         if (!done) begin
            step();
            if (trigger || clear) begin
               idx  = i;
               done = 1'b1;
            end
         end
      end
   endtask

   task automatic enter_digit(input logic [3:0] val, input string tag,
                              input logic [3:0] exp_cnt, input logic exp_done);
      sw = val;
      steps(3);
      btn_enter = 1'b1;
      wait_evt(n);
      check({tag, "_lat"}, n, LAT);
      check({tag, "_trig"}, trigger, 1'b1);
      check({tag, "_digit"}, digit, val);
      check({tag, "_cnt"}, digit_count, exp_cnt);
      check({tag, "_done"}, code_done, exp_done);
      btn_enter = 1'b0;
      steps(10);
   endtask

   initial begin
      reset_n   = 1'b0;
      sw        = 4'h0;
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      steps(3);
      check("rst_digit", digit, 4'h0);
      check("rst_trig", trigger, 1'b0);
      check("rst_clear", clear, 1'b0);
      check("rst_done", code_done, 1'b0);
      check("rst_cnt", digit_count, 2'd0);
      reset_n = 1'b1;
      steps(2);

      // clean press held long: one trigger, no repeat
      sw = 4'h7;
      steps(3);
      trig_cnt = 0;
      btn_enter = 1'b1;
      wait_evt(n);
      check("clean_lat", n, LAT);
      check("clean_digit", digit, 4'h7);
      check("clean_cnt", digit_count, 2'd1);
      steps(20);
      check("clean_norepeat", trig_cnt, 1);
      btn_enter = 1'b0;
      steps(10);

      // bounce 1,1,0,1,1,0 then steady high
      trig_cnt = 0;
      btn_enter = 1'b1; step();
      btn_enter = 1'b1; step();
      btn_enter = 1'b0; step();
      btn_enter = 1'b1; step();
      btn_enter = 1'b1; step();
      btn_enter = 1'b0; step();
      check("bounce_none", trig_cnt, 0);
      btn_enter = 1'b1;
      wait_evt(n);
      check("bounce_lat", n, LAT);
      check("bounce_cnt", digit_count, 2'd2);
      steps(10);
      check("bounce_single", trig_cnt, 1);
      btn_enter = 1'b0;
      steps(10);

      // CLEAR press resets the position but keeps the digit
      btn_clear = 1'b1;
      wait_evt(n);
      check("clr_lat", n, LAT);
      check("clr_pulse", clear, 1'b1);
      check("clr_cnt", digit_count, 2'd0);
      check("clr_digit", digit, 4'h7);
      step();
      check("clr_onecycle", clear, 1'b0);
      btn_clear = 1'b0;
      steps(10);

      // full four-digit code
      enter_digit(4'h1, "c1", 2'd1, 1'b0);
      enter_digit(4'h2, "c2", 2'd2, 1'b0);
      enter_digit(4'h3, "c3", 2'd3, 1'b0);
      enter_digit(4'h4, "c4", 2'd0, 1'b1);

      // simultaneous ENTER and CLEAR after two digits: CLEAR wins, ENTER consumed
      enter_digit(4'h5, "s1", 2'd1, 1'b0);
      enter_digit(4'h9, "s2", 2'd2, 1'b0);
      sw = 4'h3;
      steps(3);
      trig_cnt = 0;
      btn_enter = 1'b1;
      btn_clear = 1'b1;
      wait_evt(n);
      check("sim_lat", n, LAT);
      check("sim_clear", clear, 1'b1);
      check("sim_trig", trigger, 1'b0);
      check("sim_done", code_done, 1'b0);
      check("sim_digit", digit, 4'h9);
      check("sim_cnt", digit_count, 2'd0);
      steps(10);
      check("sim_consumed", trig_cnt, 0);
      btn_enter = 1'b0;
      btn_clear = 1'b0;
      steps(10);
      enter_digit(4'h3, "sim_after", 2'd1, 1'b0);

      // reset mid PRESS_WAIT with ENTER held through reset
      sw = 4'h6;
      steps(3);
      btn_enter = 1'b1;
      steps(4);
      reset_n = 1'b0;
      #1;
      check("mid_rst_digit", digit, 4'h0);
      check("mid_rst_cnt", digit_count, 2'd0);
      check("mid_rst_trig", trigger, 1'b0);
      steps(3);
      reset_n = 1'b1;
      wait_evt(n);
      check("mid_rst_lat", n, LAT);
      check("mid_rst_digit6", digit, 4'h6);
      check("mid_rst_cnt1", digit_count, 2'd1);
      clr_cnt = 0;
      btn_enter = 1'b0;
      steps(10);

      // inactivity with a partial code
      steps(60);
`ifdef KEY_ENTRY_TIMEOUT_EN
      check("to_pulses", clr_cnt, 1);
      check("to_cnt", digit_count, 2'd0);
`else
      check("to_pulses", clr_cnt, 0);
      check("to_cnt", digit_count, 2'd1);
`endif
      check("to_digit", digit, 4'h6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
